// File: rtl/game_pkg.sv
// Shared game-side types and clock-domain default timing constants.
package game_pkg;

    typedef enum logic [1:0] {
        KS_IDLE,
        KS_DELAY,
        KS_REPEAT
    } key_state_t;

    localparam int unsigned GAME_DEBOUNCE_CYCLES = 4;
    localparam int unsigned GAME_REPEAT_DELAY    = 8;
    localparam int unsigned GAME_REPEAT_RATE     = 4;
    localparam int unsigned GAME_CNT_W           = 8;

endpackage

// File: rtl/key_channel.sv
// One key input: 2-FF sync, debounce, press edge and hold-to-repeat.
// pulse_c is the next-cycle pulse; the top registers it after masking.
module key_channel
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = GAME_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = GAME_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE     = GAME_REPEAT_RATE,
    parameter int unsigned CNT_W           = GAME_CNT_W
) (
    input  logic CLK,
    input  logic RST,
    input  logic key,
    output logic pulse_c
);

    logic             s1;
    logic             s2;
    logic             db;
    logic [CNT_W-1:0] cnt;
    key_state_t       state;
    key_state_t       state_d;
    logic [CNT_W-1:0] rcnt;
    logic [CNT_W-1:0] rcnt_d;

    // Synchroniser and debounce: level changes only after enough consecutive mismatches.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            db  <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= key;
            s2 <= s1;
            if (s2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db  <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= KS_IDLE;
            rcnt  <= '0;
        end else begin
            state <= state_d;
            rcnt  <= rcnt_d;
        end
    end

    // Repeat scheduler; a release seen in the same cycle as a due repeat suppresses it.
    always_comb begin
        state_d = state;
        rcnt_d  = rcnt;
        pulse_c = 1'b0;
        case (state)
            KS_IDLE: begin
                if (db) begin
                    pulse_c = 1'b1;
                    state_d = KS_DELAY;
                    rcnt_d  = CNT_W'(1);
                end
            end
            KS_DELAY: begin
                if (!db) begin
                    state_d = KS_IDLE;
                    rcnt_d  = '0;
                end else if (REPEAT_DELAY != 0 && rcnt == CNT_W'(REPEAT_DELAY)) begin
                    pulse_c = 1'b1;
                    state_d = KS_REPEAT;
                    rcnt_d  = CNT_W'(1);
                end else if (rcnt != '1) begin
                    rcnt_d = rcnt + CNT_W'(1);
                end
            end
            KS_REPEAT: begin
                if (!db) begin
                    state_d = KS_IDLE;
                    rcnt_d  = '0;
                end else if (rcnt == CNT_W'(REPEAT_RATE)) begin
                    pulse_c = 1'b1;
                    rcnt_d  = CNT_W'(1);
                end else begin
                    rcnt_d = rcnt + CNT_W'(1);
                end
            end
            default: begin
                state_d = KS_IDLE;
                rcnt_d  = '0;
            end
        endcase
    end

endmodule

// File: rtl/move_pulse_gen.sv
// Ship L/R move pulse generator: two key channels plus mutual-exclusion masking.
module move_pulse_gen
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = GAME_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = GAME_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE     = GAME_REPEAT_RATE,
    parameter int unsigned CNT_W           = GAME_CNT_W
) (
    input  logic CLK,
    input  logic RST,
    input  logic KEY_L,
    input  logic KEY_R,
    output logic L,
    output logic R
);

    logic pulse_l_c;
    logic pulse_r_c;

    key_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE),
        .CNT_W          (CNT_W)
    ) u_chan_l (
        .CLK    (CLK),
        .RST    (RST),
        .key    (KEY_L),
        .pulse_c(pulse_l_c)
    );

    key_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE),
        .CNT_W          (CNT_W)
    ) u_chan_r (
        .CLK    (CLK),
        .RST    (RST),
        .key    (KEY_R),
        .pulse_c(pulse_r_c)
    );

    // Coincident pulses cancel; both channels keep their own repeat phase.
    always_ff @(posedge CLK) begin
        if (RST) begin
            L <= 1'b0;
            R <= 1'b0;
        end else begin
            L <= pulse_l_c & ~pulse_r_c;
            R <= pulse_r_c & ~pulse_l_c;
        end
    end

endmodule
